// File: rtl/bus_source_mux_reg.sv
//------------------------------------------------------------------------------
// bus_source_mux_reg
//
// Registered N-source bus multiplexer for the 16-bit CPU datapath. A stored
// select register picks one of NUM_SRC sources. The register is either loaded
// directly or auto-stepped through the sources in scan mode. The selected data
// is registered onto dout, qualified by dout_valid. A hold input freezes all
// state. An illegal select load is rejected and flagged with a one-cycle
// sel_err pulse.
//
// Parameters:
//   WIDTH    data width of every source and of dout
//   NUM_SRC  number of sources, legal range 2..16
//   SEL_W    derived select width, clog2(NUM_SRC) with a minimum of 1
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   din         in   flattened sources; source k is din[k*WIDTH +: WIDTH]
//   sel_in      in   select value to load
//   sel_load    in   load sel_in into the select register
//   mode        in   0 = direct (select held), 1 = scan (select steps each edge)
//   hold        in   freeze select, dout and dout_valid
//   dout        out  registered selected data
//   dout_valid  out  dout holds a sampled value
//   cur_sel     out  current select register value
//   wrap        out  one-cycle pulse when scan steps from NUM_SRC-1 to 0
//   sel_err     out  one-cycle pulse when a load presents sel_in >= NUM_SRC
//------------------------------------------------------------------------------
module bus_source_mux_reg #(
    parameter int   WIDTH   = 16,
    parameter int   NUM_SRC = 4,
    localparam int  SEL_W   = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SRC*WIDTH-1:0]   din,
    input  logic [SEL_W-1:0]           sel_in,
    input  logic                       sel_load,
    input  logic                       mode,
    input  logic                       hold,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [SEL_W-1:0]           cur_sel,
    output logic                       wrap,
    output logic                       sel_err
);

    // Highest legal select code; scan wraps here rather than at 2^SEL_W-1.
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_SRC - 1);
    // Source count widened by one bit so NUM_SRC itself is representable
    // when it is a power of two.
    localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W + 1)'(NUM_SRC);

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic [WIDTH-1:0] dout_q,    dout_d;
    logic             valid_q,   valid_d;
    logic             wrap_q,    wrap_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] mux_data;
    logic             sel_legal;

    //--------------------------------------------------------------------------
    // Source selection from the pre-edge select register. Only legal codes
    // are decoded; unused codes can never be stored, so they read as zero.
    //--------------------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_q == SEL_W'(k)) begin
                mux_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_legal = ({1'b0, sel_in} < NUM_SRC_EXT);

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        // Defaults: hold all state, pulses return to zero.
        sel_d     = sel_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;

        if (!hold) begin
            // Capture uses the select value present before this edge.
            dout_d  = mux_data;
            valid_d = 1'b1;

            // A load request always wins over scan, even when it is rejected.
            if (sel_load) begin
                if (sel_legal) begin
                    sel_d = sel_in;
                end else begin
                    sel_err_d = 1'b1;
                end
            end else if (mode) begin
                if (sel_q == LAST_SEL) begin
                    sel_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign cur_sel    = sel_q;
    assign wrap       = wrap_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_bus_source_mux_reg.sv
//------------------------------------------------------------------------------
// Testbench for bus_source_mux_reg. Two instances share all control inputs:
// u_dut4 (NUM_SRC=4, power of two) and u_dut3 (NUM_SRC=3, unused code 3).
// Directed scenarios use fixed expectations; the random scenario compares
// both instances against a behavioural model written from the select,
// scan and hold rules using plain modulo arithmetic.
//------------------------------------------------------------------------------
module tb_bus_source_mux_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] din4;
    logic [47:0] din3;
    logic [1:0]  sel_in;
    logic        sel_load;
    logic        mode;
    logic        hold;

    logic [15:0] dout4, dout3;
    logic        valid4, valid3;
    logic [1:0]  cur_sel4, cur_sel3;
    logic        wrap4, wrap3;
    logic        err4, err3;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bus_source_mux_reg #(.WIDTH(16), .NUM_SRC(4)) u_dut4 (
        .clock      (clk),
        .reset      (reset),
        .din        (din4),
        .sel_in     (sel_in),
        .sel_load   (sel_load),
        .mode       (mode),
        .hold       (hold),
        .dout       (dout4),
        .dout_valid (valid4),
        .cur_sel    (cur_sel4),
        .wrap       (wrap4),
        .sel_err    (err4)
    );

    bus_source_mux_reg #(.WIDTH(16), .NUM_SRC(3)) u_dut3 (
        .clock      (clk),
        .reset      (reset),
        .din        (din3),
        .sel_in     (sel_in),
        .sel_load   (sel_load),
        .mode       (mode),
        .hold       (hold),
        .dout       (dout3),
        .dout_valid (valid3),
        .cur_sel    (cur_sel3),
        .wrap       (wrap3),
        .sel_err    (err3)
    );

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    //--------------------------------------------------------------------------
    // Behavioural model (index 0 -> 4 sources, index 1 -> 3 sources)
    //--------------------------------------------------------------------------
    int          m_sel   [2];
    logic [15:0] m_dout  [2];
    bit          m_valid [2];
    bit          m_wrap  [2];
    bit          m_err   [2];

    task automatic model_step(input int idx);
        int n;
        n = (idx == 0) ? 4 : 3;
        if (reset) begin
            m_sel[idx] = 0; m_dout[idx] = '0; m_valid[idx] = 0;
            m_wrap[idx] = 0; m_err[idx] = 0;
        end else if (hold) begin
            m_wrap[idx] = 0; m_err[idx] = 0;
        end else begin
            m_dout[idx]  = (idx == 0) ? din4[m_sel[idx]*16 +: 16]
                                      : din3[m_sel[idx]*16 +: 16];
            m_valid[idx] = 1;
            m_wrap[idx]  = 0;
            m_err[idx]   = 0;
            if (sel_load) begin
                if (int'(sel_in) < n) m_sel[idx] = int'(sel_in);
                else                  m_err[idx] = 1;
            end else if (mode) begin
                m_sel[idx]  = (m_sel[idx] + 1) % n;
                m_wrap[idx] = (m_sel[idx] == 0);
            end
        end
    endtask

    //--------------------------------------------------------------------------
    // 1. Reset and release
    //--------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1; mode = 0; sel_load = 0; hold = 0; sel_in = 2'd0;
        tick(); tick();
        tests_run++;
        if (dout4 !== 16'h0000 || valid4 !== 1'b0 || cur_sel4 !== 2'd0 ||
            wrap4 !== 1'b0 || err4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: dout=%h valid=%b sel=%0d wrap=%b err=%b, want 0000 0 0 0 0",
                     dout4, valid4, cur_sel4, wrap4, err4);
        end
        reset = 0;
        tick();
        tests_run++;
        if (dout4 !== 16'hAAAA || valid4 !== 1'b1 || cur_sel4 !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_release: dout=%h valid=%b sel=%0d, want aaaa 1 0",
                     dout4, valid4, cur_sel4);
        end
    endtask

    //--------------------------------------------------------------------------
    // 2. Direct load latency
    //--------------------------------------------------------------------------
    task automatic test_load();
        sel_in = 2'd2; sel_load = 1;
        tick();                     // edge N
        sel_load = 0;
        tests_run++;
        if (cur_sel4 !== 2'd2 || dout4 !== 16'hAAAA || wrap4 !== 1'b0 || err4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_edge_n: sel=%0d dout=%h wrap=%b err=%b, want 2 aaaa 0 0",
                     cur_sel4, dout4, wrap4, err4);
        end
        tick();                     // edge N+1
        tests_run++;
        if (cur_sel4 !== 2'd2 || dout4 !== 16'hCCCC || wrap4 !== 1'b0 || err4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_edge_n1: sel=%0d dout=%h wrap=%b err=%b, want 2 cccc 0 0",
                     cur_sel4, dout4, wrap4, err4);
        end
    endtask

    //--------------------------------------------------------------------------
    // 3. Scan sequence with wrap
    //--------------------------------------------------------------------------
    task automatic test_scan();
        int          exp_sel  [6] = '{1, 2, 3, 0, 1, 2};
        logic [15:0] exp_dout [6] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hAAAA, 16'hBBBB};
        bit          exp_wrap [6] = '{0, 0, 0, 1, 0, 0};
        sel_in = 2'd0; sel_load = 1;
        tick();
        sel_load = 0; mode = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (int'(cur_sel4) != exp_sel[i] || dout4 !== exp_dout[i] ||
                wrap4 !== exp_wrap[i] || err4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL scan_step%0d: sel=%0d dout=%h wrap=%b err=%b, want %0d %h %b 0",
                         i, cur_sel4, dout4, wrap4, err4, exp_sel[i], exp_dout[i], exp_wrap[i]);
            end
        end
    endtask

    //--------------------------------------------------------------------------
    // 4. Hold in the middle of a scan
    //--------------------------------------------------------------------------
    task automatic test_hold();
        // Scan continues from 2: 3, 0, 1.
        tick(); tick(); tick();
        tests_run++;
        if (cur_sel4 !== 2'd1 || dout4 !== 16'hAAAA) begin
            tests_failed++;
            $display("FAIL hold_setup: sel=%0d dout=%h, want 1 aaaa", cur_sel4, dout4);
        end
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (cur_sel4 !== 2'd1 || dout4 !== 16'hAAAA || valid4 !== 1'b1 ||
                wrap4 !== 1'b0 || err4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: sel=%0d dout=%h valid=%b wrap=%b err=%b, want 1 aaaa 1 0 0",
                         i, cur_sel4, dout4, valid4, wrap4, err4);
            end
        end
        hold = 0;
        tick();
        tests_run++;
        if (cur_sel4 !== 2'd2 || dout4 !== 16'hBBBB) begin
            tests_failed++;
            $display("FAIL hold_resume: sel=%0d dout=%h, want 2 bbbb", cur_sel4, dout4);
        end
        mode = 0;
    endtask

    //--------------------------------------------------------------------------
    // 5. Non-power-of-two source count: illegal load and short wrap
    //--------------------------------------------------------------------------
    task automatic test_illegal_sel();
        int exp_sel  [3] = '{1, 2, 0};
        bit exp_wrap [3] = '{0, 0, 1};
        sel_in = 2'd0; sel_load = 1;
        tick();
        sel_in = 2'd3;
        tick();
        sel_load = 0;
        tests_run++;
        if (err3 !== 1'b1 || cur_sel3 !== 2'd0 || wrap3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_load: err=%b sel=%0d wrap=%b, want 1 0 0", err3, cur_sel3, wrap3);
        end
        tests_run++;
        if (err4 !== 1'b0 || cur_sel4 !== 2'd3) begin
            tests_failed++;
            $display("FAIL legal_load_4src: err=%b sel=%0d, want 0 3", err4, cur_sel4);
        end
        tick();
        tests_run++;
        if (err3 !== 1'b0 || cur_sel3 !== 2'd0) begin
            tests_failed++;
            $display("FAIL illegal_pulse_end: err=%b sel=%0d, want 0 0", err3, cur_sel3);
        end
        mode = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (int'(cur_sel3) != exp_sel[i] || wrap3 !== exp_wrap[i]) begin
                tests_failed++;
                $display("FAIL scan3_step%0d: sel=%0d wrap=%b, want %0d %b",
                         i, cur_sel3, wrap3, exp_sel[i], exp_wrap[i]);
            end
        end
        mode = 0;
    endtask

    //--------------------------------------------------------------------------
    // 6. Load beats scan, then reset mid-scan (and reset beats hold)
    //--------------------------------------------------------------------------
    task automatic test_load_priority_and_reset();
        sel_in = 2'd3; sel_load = 1;
        tick();
        sel_in = 2'd0; mode = 1;
        tick();
        sel_load = 0;
        tests_run++;
        if (cur_sel4 !== 2'd0 || wrap4 !== 1'b0 || err4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_over_scan: sel=%0d wrap=%b err=%b, want 0 0 0", cur_sel4, wrap4, err4);
        end
        tick(); tick();
        reset = 1; hold = 1;
        tick();
        tests_run++;
        if (dout4 !== 16'h0000 || valid4 !== 1'b0 || cur_sel4 !== 2'd0 ||
            wrap4 !== 1'b0 || err4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_scan: dout=%h valid=%b sel=%0d wrap=%b err=%b, want 0000 0 0 0 0",
                     dout4, valid4, cur_sel4, wrap4, err4);
        end
        reset = 0; hold = 0; mode = 0;
    endtask

    //--------------------------------------------------------------------------
    // Randomized run against the model
    //--------------------------------------------------------------------------
    task automatic test_random();
        reset = 1; hold = 0; sel_load = 0; mode = 0;
        model_step(0); model_step(1);
        tick();
        for (int c = 0; c < 400; c++) begin
            din4     = {$urandom(), $urandom()};
            din3     = {16'($urandom()), $urandom()};
            reset    = ($urandom_range(0, 49) == 0);
            hold     = ($urandom_range(0, 4) == 0);
            sel_load = ($urandom_range(0, 3) == 0);
            sel_in   = 2'($urandom_range(0, 3));
            mode     = 1'($urandom_range(0, 1));
            model_step(0);
            model_step(1);
            tick();
            tests_run++;
            if (dout4 !== m_dout[0] || valid4 !== m_valid[0] || int'(cur_sel4) != m_sel[0] ||
                wrap4 !== m_wrap[0] || err4 !== m_err[0]) begin
                tests_failed++;
                $display("FAIL rand4_c%0d: dout=%h valid=%b sel=%0d wrap=%b err=%b, want %h %b %0d %b %b",
                         c, dout4, valid4, cur_sel4, wrap4, err4,
                         m_dout[0], m_valid[0], m_sel[0], m_wrap[0], m_err[0]);
            end
            tests_run++;
            if (dout3 !== m_dout[1] || valid3 !== m_valid[1] || int'(cur_sel3) != m_sel[1] ||
                wrap3 !== m_wrap[1] || err3 !== m_err[1]) begin
                tests_failed++;
                $display("FAIL rand3_c%0d: dout=%h valid=%b sel=%0d wrap=%b err=%b, want %h %b %0d %b %b",
                         c, dout3, valid3, cur_sel3, wrap3, err3,
                         m_dout[1], m_valid[1], m_sel[1], m_wrap[1], m_err[1]);
            end
        end
    endtask

    initial begin
        din4     = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        din3     = {16'h3333, 16'h2222, 16'h1111};
        reset    = 1;
        sel_in   = 2'd0;
        sel_load = 0;
        mode     = 0;
        hold     = 0;
        #2;
        test_reset();
        test_load();
        test_scan();
        test_hold();
        test_illegal_sel();
        test_load_priority_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
